psum_axis_packer: RTL and testbench

Output-side serializer for the convolution accelerator: captures the wide partial-sum vector produced by the MAC array and streams it to the DMA as AXI4-Stream master beats with full backpressure. It replaces the raw, unhandshaked psum bus at the top level. A two-entry vector buffer lets the MAC array deliver the next vector while the current one drains. Lane count, lane width, beat width and lanes-per-beat are parametrised.

---
 rtl/psum_axis_packer.sv | 135 +++++++++++++
 tb/tb_psum_axis_packer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/psum_axis_packer.sv
// Two-slot partial-sum buffer feeding an AXI4-Stream master, LANES_PER_BEAT lanes per beat.
// Optional build macro PSUM_RELU_EN clamps negative lanes to zero before sign extension.

module psum_lane_fmt #(
   parameter int IN_W  = 20,
   parameter int OUT_W = 32
) (
   input  logic [IN_W-1:0]  lane,
   output logic [OUT_W-1:0] fmt
);
   logic [IN_W-1:0] act;
`ifdef PSUM_RELU_EN
   assign act = lane[IN_W-1] ? '0 : lane;
`else
   assign act = lane;
`endif
   assign fmt = OUT_W'($signed(act));
endmodule

module psum_axis_packer #(
   parameter int PSUM_LANES           = 64,
   parameter int PSUM_WIDTH           = 20,
   parameter int C_M_AXIS_TDATA_WIDTH = 32,
   parameter int LANES_PER_BEAT       = 1
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [PSUM_LANES*PSUM_WIDTH-1:0]    psum_in,
   input  logic                                psum_valid,
   input  logic                                vec_last,
   output logic                                psum_ready,
   output logic                                M_AXIS_TVALID,
   output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
   output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
   output logic                                M_AXIS_TLAST,
   input  logic                                M_AXIS_TREADY,
   output logic                                layer_done,
   output logic [15:0]                         vectors_sent
);
   localparam int LANE_OUT = C_M_AXIS_TDATA_WIDTH / LANES_PER_BEAT;
   localparam int BEATS    = PSUM_LANES / LANES_PER_BEAT;
   localparam int BI_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int VEC_W    = PSUM_LANES * PSUM_WIDTH;
   localparam logic [BI_W-1:0] BI_LAST = BI_W'(BEATS - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t           state, state_nxt;
   logic [VEC_W-1:0] slot_data [2];
   logic [1:0]       slot_last;
   logic             wp, rp;
   logic [1:0]       cnt, cnt_nxt;
   logic [BI_W-1:0]  bi, bi_nxt;
   logic             wr_en, beat_acc, vec_done;
   logic [VEC_W-1:0] rd_vec;
   logic [LANES_PER_BEAT-1:0][LANE_OUT-1:0] beat_lanes;

   // Ready depends only on registered occupancy; a draining slot is not reused in the same cycle.
   assign psum_ready    = (cnt != 2'd2);
   assign wr_en         = psum_valid && psum_ready;
   assign M_AXIS_TVALID = (state == SEND);
   assign beat_acc      = M_AXIS_TVALID && M_AXIS_TREADY;
   assign vec_done      = beat_acc && (bi == BI_LAST);
   assign rd_vec        = slot_data[rp];
   assign M_AXIS_TLAST  = M_AXIS_TVALID && slot_last[rp] && (bi == BI_LAST);
   assign M_AXIS_TSTRB  = '1;
   assign M_AXIS_TDATA  = C_M_AXIS_TDATA_WIDTH'(beat_lanes);

   genvar j;
   generate
      for (j = 0; j < LANES_PER_BEAT; j++) begin : g_lane
         psum_lane_fmt #(.IN_W(PSUM_WIDTH), .OUT_W(LANE_OUT)) u_fmt (
            .lane (rd_vec[(int'(bi) * LANES_PER_BEAT + j) * PSUM_WIDTH +: PSUM_WIDTH]),
            .fmt  (beat_lanes[j])
         );
      end
   endgenerate

   always_comb begin
      cnt_nxt = cnt;
      if (wr_en && !vec_done)
         cnt_nxt = cnt + 2'd1;
      else if (!wr_en && vec_done)
         cnt_nxt = cnt - 2'd1;
   end

   always_comb begin
      state_nxt = state;
      bi_nxt    = bi;
      case (state)
         IDLE: if (cnt_nxt != 2'd0) state_nxt = SEND;
         SEND: begin
            if (beat_acc) begin
               if (bi == BI_LAST) begin
                  bi_nxt = '0;
                  if (cnt_nxt == 2'd0) state_nxt = IDLE;
               end else begin
                  bi_nxt = bi + BI_W'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         bi           <= '0;
         wp           <= 1'b0;
         rp           <= 1'b0;
         vectors_sent <= '0;
         layer_done   <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         bi         <= bi_nxt;
         layer_done <= vec_done && slot_last[rp];
         if (wr_en) wp <= ~wp;
         if (vec_done) begin
            rp           <= ~rp;
            vectors_sent <= vectors_sent + 16'd1;
         end
      end
   end

   // Slot contents need no reset: occupancy and pointers gate every read.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         slot_data[wp] <= psum_in;
         slot_last[wp] <= vec_last;
      end
   end
endmodule

// File: tb/tb_psum_axis_packer.sv
// Scoreboard bench for psum_axis_packer with 4 lanes x 20 bits, one lane per 32-bit beat.
module tb_psum_axis_packer;
   localparam int L = 4;
   localparam int W = 20;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [L*W-1:0] psum_in = '0;
   logic          psum_valid = 1'b0;
   logic          vec_last = 1'b0;
   logic          psum_ready;
   logic          tvalid;
   logic [31:0]   tdata;
   logic [3:0]    tstrb;
   logic          tlast;
   logic          tready = 1'b0;
   logic          layer_done;
   logic [15:0]   vectors_sent;

   psum_axis_packer #(
      .PSUM_LANES(L), .PSUM_WIDTH(W), .C_M_AXIS_TDATA_WIDTH(32), .LANES_PER_BEAT(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .psum_in(psum_in), .psum_valid(psum_valid),
      .vec_last(vec_last), .psum_ready(psum_ready), .M_AXIS_TVALID(tvalid),
      .M_AXIS_TDATA(tdata), .M_AXIS_TSTRB(tstrb), .M_AXIS_TLAST(tlast),
      .M_AXIS_TREADY(tready), .layer_done(layer_done), .vectors_sent(vectors_sent)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] data; bit last; } beat_t;
   beat_t sbq[$];
   int    cur_lanes [L];
   int    errors = 0, checks = 0;
   int    n_tl = 0, n_ld = 0;
   int    tr_mode = 0;   // 0: sink stalled, 1: sink ready, 2: random
   bit    prev_tl = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a lane is its integer value as a 32-bit two's-complement word.
   function automatic logic [31:0] exp_lane(input int v);
`ifdef PSUM_RELU_EN
      if (v < 0) v = 0;
`endif
      return 32'(v);
   endfunction

   always begin
      @(posedge clk);
      #2;
      case (tr_mode)
         0: tready = 1'b0;
         1: tready = 1'b1;
         default: tready = 1'($urandom_range(0, 1));
      endcase
   end

   // Capture monitor: every accepted vector yields L expected beats.
   always @(negedge clk) begin
      if (rst_n && psum_valid && psum_ready) begin
         for (int b = 0; b < L; b++) begin
            beat_t e;
            e.data = exp_lane(cur_lanes[b]);
            e.last = vec_last && (b == L - 1);
            sbq.push_back(e);
         end
      end
   end

   // Output monitor
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_tl = 1'b0;
      end else begin
         chk("layer_done", 64'(layer_done), 64'(prev_tl));
         if (layer_done) n_ld++;
         if (tvalid) begin
            if (sbq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_beat: got tdata %0h expected no beat at %0t", tdata, $time);
            end else begin
               chk("tdata", 64'(tdata), 64'(sbq[0].data));
               chk("tlast", 64'(tlast), 64'(sbq[0].last));
               if (tready) begin
                  if (tlast) n_tl++;
                  void'(sbq.pop_front());
               end
            end
         end
         prev_tl = tvalid && tready && tlast;
      end
   end

   task automatic set_lanes(input int a, input int b, input int c, input int d);
      cur_lanes[0] = a; cur_lanes[1] = b; cur_lanes[2] = c; cur_lanes[3] = d;
   endtask

   task automatic send_vec(input bit last);
      int n = 0;
      for (int i = 0; i < L; i++) psum_in[i*W +: W] = W'(cur_lanes[i]);
      psum_valid = 1'b1;
      vec_last   = last;
      do begin @(negedge clk); n++; end while (!psum_ready && n < 200);
      if (!psum_ready) begin
         checks++; errors++;
         $display("FAIL send_timeout: got psum_ready 0 expected 1 within 200 cycles");
      end
      @(posedge clk); #1;
      psum_valid = 1'b0;
      vec_last   = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((sbq.size() != 0 || tvalid) && n < 2000) begin @(negedge clk); n++; end
      chk("drain_empty", 64'(sbq.size()), 64'd0);
      @(negedge clk);
   endtask

   task automatic apply_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      sbq.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_tvalid", 64'(tvalid), 0);
      chk("rst_tlast", 64'(tlast), 0);
      chk("rst_layer_done", 64'(layer_done), 0);
      chk("rst_psum_ready", 64'(psum_ready), 1);
      chk("rst_vectors_sent", 64'(vectors_sent), 0);
      chk("tstrb", 64'(tstrb), 64'hF);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Single vector, sink always ready: four consecutive beats
      tr_mode = 1;
      set_lanes(3, -1, 32'h7FFFF, -32'h80000);
      send_vec(1'b1);
      for (int k = 0; k < L; k++) begin @(negedge clk); chk("t1_tvalid", 64'(tvalid), 1); end
      @(negedge clk);
      chk("t1_idle", 64'(tvalid), 0);
      chk("t1_layer_done", 64'(layer_done), 1);
      chk("t1_vectors_sent", 64'(vectors_sent), 1);

      // Backpressure: two vectors fill the buffer, third held off
      tr_mode = 0;
      @(posedge clk); #1;
      set_lanes(10, -20, 30, -40);  send_vec(1'b0);
      set_lanes(-50, 60, -70, 80);  send_vec(1'b0);
      set_lanes(111, 222, -333, 444);
      for (int i = 0; i < L; i++) psum_in[i*W +: W] = W'(cur_lanes[i]);
      psum_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk("bp_psum_ready", 64'(psum_ready), 0);
         chk("bp_tvalid_held", 64'(tvalid), 1);
      end
      @(posedge clk); #1;
      tr_mode = 1;
      fork
         send_vec(1'b1);
         for (int k = 0; k < 3 * L; k++) begin @(negedge clk); chk("bp_no_bubble", 64'(tvalid), 1); end
      join
      @(negedge clk);
      chk("bp_idle", 64'(tvalid), 0);
      chk("bp_vectors_sent", 64'(vectors_sent), 4);

      // Capture on the same edge as the final beat of the only buffered vector
      @(posedge clk); #1;
      set_lanes(1, 2, 3, 4);   send_vec(1'b0);
      repeat (3) begin @(posedge clk); #1; end
      set_lanes(-9, 8, -7, 6); send_vec(1'b0);
      @(negedge clk);
      chk("sim_psum_ready", 64'(psum_ready), 1);
      chk("sim_tvalid", 64'(tvalid), 1);
      for (int k = 1; k < L; k++) begin @(negedge clk); chk("sim_no_bubble", 64'(tvalid), 1); end
      @(negedge clk);
      chk("sim_idle", 64'(tvalid), 0);

      // ReLU-sensitive vector (model applies ReLU only when the macro is defined)
      @(posedge clk); #1;
      set_lanes(-5, 7, -1, 0); send_vec(1'b1);
      drain();
      chk("relu_vectors_sent", 64'(vectors_sent), 7);

      // Reset mid-vector after two beats
      @(posedge clk); #1;
      set_lanes(1000, 2000, 3000, 4000); send_vec(1'b1);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b0;
      sbq.delete();
      #1;
      chk("mid_rst_tvalid", 64'(tvalid), 0);
      chk("mid_rst_psum_ready", 64'(psum_ready), 1);
      chk("mid_rst_vectors_sent", 64'(vectors_sent), 0);
      chk("mid_rst_tlast", 64'(tlast), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      set_lanes(-123, 456, -789, 1011); send_vec(1'b0);
      @(negedge clk);
      chk("post_rst_tvalid", 64'(tvalid), 1);
      chk("post_rst_lane0", 64'(tdata), 64'(exp_lane(-123)));
      drain();
      chk("post_rst_vectors_sent", 64'(vectors_sent), 1);

      // Random sink readiness, 100 vectors, vec_last on every 10th
      apply_reset();
      n_tl = 0; n_ld = 0;
      tr_mode = 2;
      for (int v = 0; v < 100; v++) begin
         for (int i = 0; i < L; i++) cur_lanes[i] = int'($urandom_range(0, 1048575)) - 524288;
         send_vec(v % 10 == 9);
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
      drain();
      repeat (2) @(negedge clk);
      chk("rand_tlast_count", 64'(n_tl), 10);
      chk("rand_layer_done_count", 64'(n_ld), 10);
      chk("rand_vectors_sent", 64'(vectors_sent), 100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
